demultiplexer_sequencial: RTL
=============================

// Module: demultiplexer_sequencial
// PURPOSE
//  Sequential 1-to-N demultiplexer: routes a stream of W-bit words from one input,
//    in arrival order, into N_OUT output slots.
//  Sits between the keypad/code-entry front end and the code comparator.
//  Assembles one digit per handshake into a full N_OUT-digit frame.
//  Presents the frame with a valid/ready handshake.
// PARAMETERS
//  N_OUT   4   number of output slots (digits per frame), >= 2
//  W       4   width of each word/slot in bits
//  SW      2   slot-pointer width, = clog2(N_OUT); set together with N_OUT
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         synchronous reset, active-low
//  din          in   W         input word
//  din_valid    in   1         din is valid this cycle
//  din_ready    out  1         block accepts din this cycle
//  clr          in   1         abort partial frame (e.g. user cancel key)
//  sel          out  SW        index of the slot the next accepted word is written to
//  dout         out  N_OUT*W   assembled frame; slot k = dout[k*W +: W]
//  frame_valid  out  1         dout holds a complete, unconsumed frame
//  frame_ready  in   1         consumer takes the frame this cycle
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): sel=0, staging=0, dout=0, frame_valid=0.
//  Reset mid-frame discards all partial and pending data.
//  Handshake rules:
//   - Accept when din_valid && din_ready.
//   - frame_valid && frame_ready consumes the frame.
//  din_ready = !clr && !(sel==N_OUT-1 && frame_valid && !frame_ready).
//   - Combinational; it does not depend on din_valid.
//  Accept with sel<N_OUT-1: staging slot[sel] <= din, then sel <= sel+1.
//  Accept with sel==N_OUT-1 (last slot):
//   - dout <= {din, staging slots N_OUT-2..0}.
//   - frame_valid <= 1 and sel <= 0.
//   - Staging is cleared.
//   - Latency: frame_valid is visible the cycle after the last word is accepted.
//  frame_valid stays high and dout stays stable until frame_ready=1.
//  Consume with no simultaneous completion: frame_valid <= 0; dout holds its value.
//  Last-slot accept and consume in the same cycle: the new frame loads and frame_valid stays 1.
//  Backpressure:
//   - Slots 0..N_OUT-2 keep filling while an old frame waits.
//   - Only the final slot stalls.
//  clr=1:
//   - sel <= 0 and staging cleared; any din that cycle is dropped (din_ready=0).
//   - dout and frame_valid are unaffected; a frame_ready consume still happens that cycle.
//  sel wraps only through last-slot completion; it never exceeds N_OUT-1.
//  din_valid=0: no state change except the consume and clr rules above.
// STRUCTURE
//  Include file demux_defs.vh holds default N_OUT, W, SW and the slot-select macro.
//   - The code comparator shares this file.
//  Sub-module demux_decodificador_1xN (combinational):
//   - Turns sel plus the accept strobe into N_OUT one-hot write enables for the staging slots.
//  Top level holds the staging registers, the dout register, the sel counter and the handshake logic.
// TESTING (N_OUT=4, W=4)
//  1. Hold frame_ready=1, send 1,2,3,4 on consecutive cycles.
//     -> dout=16'h4321 and frame_valid=1 for exactly 1 cycle, one cycle after the 4th accept.
//  2. Hold frame_ready=0 after frame 16'h4321, then send 5,6,7.
//     -> sel=3, din_ready=0, dout still 16'h4321.
//     -> Then raise frame_ready and send 8: the next cycle gives dout=16'h8765, frame_valid=1.
//  3. Send 1,2, raise clr with din_valid=1 and din=9, then send A,B,C,D.
//     -> 9 is dropped, sel=0 after clr, final dout=16'hDCBA.
//  4. With frame_valid=1, accept the last word while frame_ready=1 in the same cycle.
//     -> frame_valid stays 1 and dout shows the new frame; no frame is lost or duplicated.
//  5. Drop rst_n for 1 cycle after 3 words are accepted and with frame_valid=1.
//     -> sel=0, dout=0, frame_valid=0, din_ready=1.
//     -> The next 4 words form a clean frame.
//  6. Random din_valid/frame_ready pattern over 1000 words.
//     -> A scoreboard sees every word in order, grouped 4 per frame, with no loss.

Source files
------------

// File: rtl/demultiplexer_sequencial_pkg.sv
// rtl/demultiplexer_sequencial_pkg.sv - shared defaults for the sequential demultiplexer
package demultiplexer_sequencial_pkg;

  // Default frame geometry; DEMUX_SW must equal clog2(DEMUX_N_OUT)
  localparam int DEMUX_N_OUT = 4;
  localparam int DEMUX_W     = 4;
  localparam int DEMUX_SW    = 2;

  // Index of the final slot, the one whose accept completes a frame
  function automatic int demux_last_slot(input int n_out);
    return n_out - 1;
  endfunction

endpackage

// File: rtl/demultiplexer_sequencial_if.sv
// rtl/demultiplexer_sequencial_if.sv - word-in / frame-out handshake bundle
interface demultiplexer_sequencial_if
  import demultiplexer_sequencial_pkg::*;
#(
  parameter int N_OUT = DEMUX_N_OUT,
  parameter int W     = DEMUX_W,
  parameter int SW    = DEMUX_SW
);
  logic [W-1:0]       din;
  logic               din_valid;
  logic               din_ready;
  logic               clr;
  logic [SW-1:0]      sel;
  logic [N_OUT*W-1:0] dout;
  logic               frame_valid;
  logic               frame_ready;

  // Producer/consumer side that drives words and takes frames
  modport master (
    output din, din_valid, clr, frame_ready,
    input  din_ready, sel, dout, frame_valid
  );

  // Demultiplexer side
  modport slave (
    input  din, din_valid, clr, frame_ready,
    output din_ready, sel, dout, frame_valid
  );
endinterface

// File: rtl/demultiplexer_sequencial_decodificador.sv
// rtl/demultiplexer_sequencial_decodificador.sv - slot pointer to one-hot write enables
module demux_decodificador_1xN #(
  parameter int N_OUT = 4,
  parameter int SW    = 2
) (
  input  logic [SW-1:0]    sel,
  input  logic             en,
  output logic [N_OUT-1:0] we
);

  // One enable per slot, raised only for the addressed slot on an accept
  always_comb begin
    we = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (en && (sel == SW'(k))) begin
        we[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demultiplexer_sequencial.sv
// rtl/demultiplexer_sequencial.sv - assembles N_OUT words into a frame with valid/ready
module demultiplexer_sequencial
  import demultiplexer_sequencial_pkg::*;
#(
  parameter int N_OUT = DEMUX_N_OUT,
  parameter int W     = DEMUX_W,
  parameter int SW    = DEMUX_SW
) (
  input logic                        clk,
  input logic                        rst_n,
  demultiplexer_sequencial_if.slave  bus
);

  localparam int LAST = demux_last_slot(N_OUT);

  logic [SW-1:0]                sel_q, sel_d;
  logic [N_OUT-2:0][W-1:0]      staging_q, staging_d;
  logic [N_OUT*W-1:0]           dout_q, dout_d;
  logic                         frame_valid_q, frame_valid_d;

  logic                         at_last;
  logic                         accept;
  logic                         consume;
  logic [N_OUT-1:0]             we;

  demux_decodificador_1xN #(
    .N_OUT (N_OUT),
    .SW    (SW)
  ) u_dec (
    .sel (sel_q),
    .en  (accept),
    .we  (we)
  );

  // Handshake: only the final slot stalls behind an unconsumed frame
  always_comb begin
    at_last       = (sel_q == SW'(LAST));
    bus.din_ready = !bus.clr && !(at_last && frame_valid_q && !bus.frame_ready);
    accept        = bus.din_valid && bus.din_ready;
    consume       = frame_valid_q && bus.frame_ready;
  end

  // Next-state: staging fill, frame completion, cancel and consume
  always_comb begin
    sel_d         = sel_q;
    staging_d     = staging_q;
    dout_d        = dout_q;
    frame_valid_d = frame_valid_q;

    if (bus.clr) begin
      sel_d     = '0;
      staging_d = '0;
    end else if (accept) begin
      for (int k = 0; k < N_OUT - 1; k++) begin
        if (we[k]) begin
          staging_d[k] = bus.din;
        end
      end
      if (we[LAST]) begin
        dout_d    = {bus.din, staging_q};
        staging_d = '0;
        sel_d     = '0;
      end else begin
        sel_d = sel_q + SW'(1);
      end
    end

    // A completing accept wins over a same-cycle consume so no frame is dropped
    if (accept && at_last) begin
      frame_valid_d = 1'b1;
    end else if (consume) begin
      frame_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q         <= '0;
      staging_q     <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      staging_q     <= staging_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Output mapping
  always_comb begin
    bus.sel         = sel_q;
    bus.dout        = dout_q;
    bus.frame_valid = frame_valid_q;
  end

endmodule
